// File: rtl/missile_pkg.sv
// Shared definitions for the missile subsystem: scheduler states and the game
// constants used by both the scheduler and the per-slot flight controllers.
package missile_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT    = 2'd1,
        WAIT_ACK = 2'd2
    } sched_state_t;

    localparam int N_MISSILE_SLOTS = 4;
    localparam int COOLDOWN_FRAMES = 30;
    localparam int SCREEN_Y_LIMIT  = 390;

endpackage

// File: rtl/cooldown_timer.sv
// Per-requester refire cooldown: loads on a grant, counts down once per video
// frame and saturates at zero.
module cooldown_timer
    import missile_pkg::*;
#(
    parameter int LOAD_VAL = 30,
    parameter int W        = 5
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         load,
    input  logic         frame_tick,
    output logic [W-1:0] count,
    output logic         cooling
);

    // A load wins over a coincident frame tick so the full cooldown is served.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= W'(LOAD_VAL);
        end else if (frame_tick && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign cooling = (count != '0);

endmodule

// File: rtl/missile_scheduler.sv
// Shares a pool of missile slots between requesters: round-robin grant,
// lowest-free slot pick, launch pulse, ack wait with timeout, refire cooldown.
module missile_scheduler
    import missile_pkg::*;
#(
    parameter int N_REQ           = 2,
    parameter int N_SLOT          = N_MISSILE_SLOTS,
    parameter int COOLDOWN_FRAMES = missile_pkg::COOLDOWN_FRAMES,
    parameter int ACK_TIMEOUT     = 4,
    parameter int OWNER_W         = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int CNT_W          = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1,
    localparam int BC_W           = $clog2(N_SLOT + 1)
) (
    input  logic                      Clk,
    input  logic                      Reset_n,
    input  logic                      frame_tick,
    input  logic [N_REQ-1:0]          launch_req,
    input  logic [N_REQ-1:0]          alive,
    input  logic [N_SLOT-1:0]         slot_busy,
    output logic [N_SLOT-1:0]         slot_launch,
    output logic [N_SLOT*OWNER_W-1:0] slot_owner,
    output logic [N_REQ-1:0]          grant,
    output logic [N_REQ-1:0]          cooling,
    output logic                      launch_drop,
    output logic [BC_W-1:0]           busy_cnt,
    output logic [1:0]                dbg_state,
    output logic [N_REQ*CNT_W-1:0]    dbg_cooldown
);

    localparam int SLOT_W = (N_SLOT > 1) ? $clog2(N_SLOT) : 1;
    localparam int TCNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    sched_state_t                    state_q, state_d;
    logic [OWNER_W-1:0]              winner_q, last_q;
    logic [SLOT_W-1:0]               slot_q;
    logic [TCNT_W-1:0]               tcnt_q;
    logic [N_SLOT-1:0]               reserved_q;
    logic [N_SLOT-1:0][OWNER_W-1:0]  owner_q;
    logic [N_REQ-1:0]                eligible;
    logic [N_SLOT-1:0]               free_slots;
    logic [N_REQ-1:0][CNT_W-1:0]     cd_count;

    function automatic logic [OWNER_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                                   input logic [OWNER_W-1:0] from);
        logic [OWNER_W-1:0] pick;
        logic               found;
        int                 idx;
        pick  = from;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(from) + k) % N_REQ;
            if (!found && |(req & (N_REQ'(1) << idx))) begin
                pick  = OWNER_W'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [SLOT_W-1:0] lowest_free(input logic [N_SLOT-1:0] free);
        logic [SLOT_W-1:0] pick;
        pick = '0;
        for (int j = N_SLOT - 1; j >= 0; j--) begin
            if (|(free & (N_SLOT'(1) << j))) begin
                pick = SLOT_W'(j);
            end
        end
        return pick;
    endfunction

    assign eligible     = launch_req & alive & ~cooling;
    assign free_slots   = ~slot_busy & ~reserved_q;
    assign slot_owner   = owner_q;
    assign busy_cnt     = BC_W'($countones(slot_busy | reserved_q));
    assign dbg_state    = state_q;
    assign dbg_cooldown = cd_count;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Launch handshake: slot_launch is a one-cycle pulse; the slot acknowledges
    // by raising slot_busy, which may already be high in the first wait cycle.
    always_comb begin
        state_d     = state_q;
        slot_launch = '0;
        grant       = '0;
        launch_drop = 1'b0;
        case (state_q)
            IDLE: begin
                if (|eligible && |free_slots) begin
                    state_d = GRANT;
                end
            end
            GRANT: begin
                slot_launch[slot_q] = 1'b1;
                grant[winner_q]     = 1'b1;
                state_d             = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (slot_busy[slot_q]) begin
                    state_d = IDLE;
                end else if (tcnt_q == TCNT_W'(ACK_TIMEOUT - 1)) begin
                    launch_drop = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The slot stays reserved from the launch until ack or timeout so the
    // picker cannot hand it out twice before slot_busy rises.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            winner_q   <= '0;
            slot_q     <= '0;
            last_q     <= OWNER_W'(N_REQ - 1);
            tcnt_q     <= '0;
            reserved_q <= '0;
            owner_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (state_d == GRANT) begin
                        winner_q <= rr_pick(eligible, last_q);
                        slot_q   <= lowest_free(free_slots);
                    end
                end
                GRANT: begin
                    reserved_q[slot_q] <= 1'b1;
                    owner_q[slot_q]    <= winner_q;
                    last_q             <= winner_q;
                    tcnt_q             <= '0;
                end
                WAIT_ACK: begin
                    if (state_d == IDLE) begin
                        reserved_q[slot_q] <= 1'b0;
                    end else begin
                        tcnt_q <= tcnt_q + TCNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar i = 0; i < N_REQ; i++) begin : g_cd
        cooldown_timer #(
            .LOAD_VAL (COOLDOWN_FRAMES),
            .W        (CNT_W)
        ) u_cd (
            .Clk        (Clk),
            .Reset_n    (Reset_n),
            .load       (grant[i]),
            .frame_tick (frame_tick),
            .count      (cd_count[i]),
            .cooling    (cooling[i])
        );
    end

endmodule
